conv55_window_gen: RTL
======================

// Module: conv55_window_gen
// PURPOSE
//  Upstream feeder for the 5x5 conv DSP stage. Takes a raster-order pixel stream.
//  Keeps 4 line buffers plus a 5x5 register window.
//  Presents 25 window pixels win_data_0..24 to the conv stage each time a full
//  5x5 neighbourhood (valid, non-padded) is available.
// PARAMETERS
//  IMG_W   32  pixels per row; must be >= 5
//  IMG_H   32  rows per frame; must be >= 5
//  DATA_W  8   pixel width; the downstream conv stage uses 8
// PORTS
//  clk          in   1       rising-edge clock, single domain
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       in_data is valid
//  in_ready     out  1       block can accept a pixel; = !win_valid || out_ready
//  in_data      in   DATA_W  pixel, raster order (row-major, left to right)
//  win_valid    out  1       win_data_* holds a complete window
//  out_ready    in   1       downstream accepts the window
//  win_data_k   out  DATA_W  k=0..24; k = r*5+c
//                            r=0 is the oldest row; c=0 is the oldest column
//  win_eof      out  1       qualifies the last window of a frame (valid with win_valid)
// BEHAVIOUR
//  Accept: a pixel is accepted on the clk edge where in_valid && in_ready.
//  Nothing changes without an accept, except that win_valid clears on out_ready.
//  Counters: col (0..IMG_W-1) and row (0..IMG_H-1) track the accepted pixel.
//   - col wraps to 0 and row increments on an accept at col=IMG_W-1.
//   - At (IMG_H-1, IMG_W-1) both wrap to 0. The next pixel starts a new frame.
//   - Line buffer and window contents carry over, but gating restarts.
//  Line buffers: lb0..lb3, each IMG_W x DATA_W. On accept at column col:
//   - Read all four at col before the write.
//   - lb3[col]<=lb2[col]; lb2[col]<=lb1[col]; lb1[col]<=lb0[col]; lb0[col]<=in_data.
//   - lb3 holds row-4 and lb0 holds row-1.
//   - Contents are not reset.
//  Window: on accept, each window row shifts left by one column.
//   - Column 4 loads {lb3,lb2,lb1,lb0,in_data}[col] into rows 0..4.
//   - win_data_24 = newest pixel (row, col); win_data_0 = (row-4, col-4).
//  FSM, 2 states:
//   - FILL: row<4. No windows are emitted.
//   - FILL->RUN on accept at (3, IMG_W-1).
//   - RUN->FILL on accept at (IMG_H-1, IMG_W-1).
//  Emission: win_valid is set on the edge after an accept in RUN with col>=4.
//   - It stays high until a cycle with out_ready=1, then clears.
//   - If another qualifying accept happens in that same cycle, win_valid stays
//     high and the window updates.
//   - While win_valid && !out_ready: in_ready=0, and window/counters hold.
//   - Latency: 1 cycle from accept to window.
//  win_eof: set with the window formed by the accept at (IMG_H-1, IMG_W-1).
//  Window counts:
//   - (IMG_W-4) windows per row, (IMG_H-4)*(IMG_W-4) per frame.
//   - Columns 0..3 of every row produce no window; no padding.
//  Reset (async assert, sync deassert is external):
//   - state=FILL; row=col=0.
//   - win_valid=0, win_eof=0, all win_data_k=0.
//   - in_ready=1 after reset.
//   - Reset mid-frame discards the partial frame. The next pixel is (0,0).
// CONFIGURATION
//  CONV55_SOF_EN defined:
//   - Adds input in_sof (1 bit), sampled only on accept.
//   - An accept with in_sof=1 forces that pixel to (0,0) and state=FILL.
//   - Any partial frame is aborted, and no win_eof is emitted for it.
//   - in_sof on a natural (0,0) pixel is a no-op.
//  Not defined: the port is absent; framing is by counters only.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 and in_ready=1 asynchronously; no window until row 4.
//  2 IMG_W=IMG_H=8, pixel=r*8+c, out_ready=1:
//    - First win_valid is 1 cycle after pixel 36: win_data_0=0, win_data_12=18, win_data_24=36.
//    - 16 windows in the frame; the last has win_data_24=63, win_data_0=27, win_eof=1.
//  3 Backpressure: hold out_ready=0 for 3 cycles while win_valid=1.
//    - in_ready=0 throughout and win_data stable.
//    - The pixel held on in_data is accepted the cycle out_ready returns; no window lost.
//  4 in_valid gaps: random 50% in_valid over one frame -> same 16 windows, same order and values as test 2.
//  5 Back-to-back frames: two 8x8 frames with no gap -> 32 windows, second frame identical to the first, 2 win_eof pulses.
//  6 CONV55_SOF_EN: in_sof=1 at pixel 45 of frame 1.
//    - Frame 1 is truncated with no win_eof.
//    - The following 64 pixels produce the 16 windows of test 2, with win_eof on the last.

Source files
------------

// File: rtl/conv55_window_gen.sv
// conv55_window_gen: 5x5 sliding-window generator feeding the conv DSP stage.
// Takes a raster-order pixel stream and keeps four line buffers plus a 5x5
// register window. A window is presented once a full non-padded 5x5
// neighbourhood is available. The last window of a frame carries win_eof.
// Optional feature: define CONV55_SOF_EN to add an in_sof input. An accepted
// pixel with in_sof=1 restarts framing at (0,0).
module conv55_window_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef CONV55_SOF_EN
    input  logic              in_sof,
`endif
    output logic              win_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] win_data_0,
    output logic [DATA_W-1:0] win_data_1,
    output logic [DATA_W-1:0] win_data_2,
    output logic [DATA_W-1:0] win_data_3,
    output logic [DATA_W-1:0] win_data_4,
    output logic [DATA_W-1:0] win_data_5,
    output logic [DATA_W-1:0] win_data_6,
    output logic [DATA_W-1:0] win_data_7,
    output logic [DATA_W-1:0] win_data_8,
    output logic [DATA_W-1:0] win_data_9,
    output logic [DATA_W-1:0] win_data_10,
    output logic [DATA_W-1:0] win_data_11,
    output logic [DATA_W-1:0] win_data_12,
    output logic [DATA_W-1:0] win_data_13,
    output logic [DATA_W-1:0] win_data_14,
    output logic [DATA_W-1:0] win_data_15,
    output logic [DATA_W-1:0] win_data_16,
    output logic [DATA_W-1:0] win_data_17,
    output logic [DATA_W-1:0] win_data_18,
    output logic [DATA_W-1:0] win_data_19,
    output logic [DATA_W-1:0] win_data_20,
    output logic [DATA_W-1:0] win_data_21,
    output logic [DATA_W-1:0] win_data_22,
    output logic [DATA_W-1:0] win_data_23,
    output logic [DATA_W-1:0] win_data_24,
    output logic              win_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // FILL: rows 0..3 are still being buffered; RUN: full windows possible.
    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t            state, state_eff, state_nxt;
    logic [CW-1:0]     col, col_eff;
    logic [RW-1:0]     row, row_eff;
    logic              accept, sof_hit, last_col, last_px, qualify;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb3 [IMG_W];
    logic [DATA_W-1:0] win [25];
    logic [DATA_W-1:0] tap [5];

    // A held window blocks input unless it is being consumed this cycle.
    assign in_ready = !win_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef CONV55_SOF_EN
    assign sof_hit = in_sof;
`else
    assign sof_hit = 1'b0;
`endif

    // Position and phase of the incoming pixel; a start-of-frame forces (0,0)/FILL.
    assign col_eff   = sof_hit ? '0 : col;
    assign row_eff   = sof_hit ? '0 : row;
    assign state_eff = sof_hit ? FILL : state;
    assign last_col  = (col_eff == CW'(IMG_W - 1));
    assign last_px   = last_col && (row_eff == RW'(IMG_H - 1));

    // Column entering the window: oldest row (lb3) on top, live pixel at the bottom.
    assign tap[0] = lb3[col_eff];
    assign tap[1] = lb2[col_eff];
    assign tap[2] = lb1[col_eff];
    assign tap[3] = lb0[col_eff];
    assign tap[4] = in_data;

    // Next-state and window-qualification decode.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        qualify   = 1'b0;
        if (accept) begin
            if (state_eff == RUN) begin
                qualify   = (col_eff >= CW'(4));
                state_nxt = last_px ? FILL : RUN;
            end else begin
                state_nxt = (last_col && (row_eff == RW'(3))) ? RUN : FILL;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end

    // Raster position of the next pixel.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_px ? '0 : row_eff + RW'(1);
            end else begin
                col <= col_eff + CW'(1);
                row <= row_eff;
            end
        end
    end

    // Line buffers: shift the column down one line, reads see pre-write contents.
    // NOTE: line-buffer memories are deliberately not reset; gating keeps stale data out of windows.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_eff] <= in_data;
            lb1[col_eff] <= lb0[col_eff];
            lb2[col_eff] <= lb1[col_eff];
            lb3[col_eff] <= lb2[col_eff];
        end
    end

    // Window shift register plus output handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win       <= '{default: '0};
            win_valid <= 1'b0;
            win_eof   <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) win[r*5+c] <= win[r*5+c+1];
                    win[r*5+4] <= tap[r];
                end
            end
            if (accept && qualify) begin
                win_valid <= 1'b1;
                win_eof   <= last_px;
            end else if (out_ready) begin
                win_valid <= 1'b0;
                win_eof   <= 1'b0;
            end
        end
    end

    assign win_data_0  = win[0];
    assign win_data_1  = win[1];
    assign win_data_2  = win[2];
    assign win_data_3  = win[3];
    assign win_data_4  = win[4];
    assign win_data_5  = win[5];
    assign win_data_6  = win[6];
    assign win_data_7  = win[7];
    assign win_data_8  = win[8];
    assign win_data_9  = win[9];
    assign win_data_10 = win[10];
    assign win_data_11 = win[11];
    assign win_data_12 = win[12];
    assign win_data_13 = win[13];
    assign win_data_14 = win[14];
    assign win_data_15 = win[15];
    assign win_data_16 = win[16];
    assign win_data_17 = win[17];
    assign win_data_18 = win[18];
    assign win_data_19 = win[19];
    assign win_data_20 = win[20];
    assign win_data_21 = win[21];
    assign win_data_22 = win[22];
    assign win_data_23 = win[23];
    assign win_data_24 = win[24];

endmodule
